dmem_arbiter: RTL

- Two-requester round-robin arbiter and access sequencer for the single-port 32x32 data memory.
- Requester 0 is the pipeline MEM stage; requester 1 is the debug/loader port, which preloads and inspects memory.
- Converts byte addresses to word indices, rejects misaligned or out-of-range accesses, and drives the memory strobes for exactly one cycle per access.
- Outputs a stall for the CPU while its access is pending.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_arbiter_rr_pick2.sv | 23 ++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// No logic here.
// No handshake; used by both requesters' arbitration and sequencing.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } dmemState_t;

    localparam int          DMEM_DEPTH      = 32;
    localparam int          DMEM_IDX_W      = 5;
    localparam logic [31:0] DMEM_BYTE_LIMIT = 32'h0000_0080;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time wins.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       sel,
    output logic       valid
);

    always_comb begin
        valid = |req;
        sel   = REQ_CPU;
        if (req == 2'b11) begin
            sel = ~last;
        end else if (req[1]) begin
            sel = REQ_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the single-port data memory (CPU vs debug port).
// Latency: gnt one cycle after the IDLE sample edge, strobe the next cycle, done/err one cycle later.
// Backpressure: requesters hold their request until gnt; the CPU is stalled until done/err.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int IDX_W  = DMEM_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [1:0]        err,
    output logic [DATA_W-1:0] rdata,
    output logic              cpu_stall,
    output logic [IDX_W-1:0]  mem_idx,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH) << 2;

    dmemState_t        state;
    dmemState_t        stateNext;
    logic              lastQ;
    logic              selQ;
    logic              weQ;

    logic              pickSel;
    logic              pickValid;
    logic [31:0]       reqAddr;
    logic [DATA_W-1:0] reqWdata;
    logic              reqWe;
    logic              badAddr;

    logic [1:0]        gntNext;
    logic [1:0]        doneNext;
    logic [1:0]        errNext;
    logic              writeNext;
    logic              readNext;
    logic              loadReq;
    logic              captureRd;

    rr_pick2 uPick (
        .req   (req),
        .last  (lastQ),
        .sel   (pickSel),
        .valid (pickValid)
    );

    assign reqAddr  = pickSel ? addr1  : addr0;
    assign reqWdata = pickSel ? wdata1 : wdata0;
    assign reqWe    = we[pickSel];
    assign badAddr  = (reqAddr[1:0] != 2'b00) || (reqAddr >= BYTE_LIMIT);

    assign cpu_stall = req[REQ_CPU] & ~done[REQ_CPU] & ~err[REQ_CPU];

    // Outputs are registered: each state's actions become visible on the cycle after its edge.
    always_comb begin
        stateNext = state;
        gntNext   = 2'b00;
        doneNext  = 2'b00;
        errNext   = 2'b00;
        writeNext = 1'b0;
        readNext  = 1'b0;
        loadReq   = 1'b0;
        captureRd = 1'b0;
        case (state)
            IDLE: begin
                if (pickValid) begin
                    loadReq          = 1'b1;
                    gntNext[pickSel] = 1'b1;
                    stateNext        = badAddr ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                writeNext = weQ;
                readNext  = ~weQ;
                stateNext = RESP;
            end
            RESP: begin
                doneNext[selQ] = 1'b1;
                captureRd      = ~weQ;
                stateNext      = IDLE;
            end
            ERR: begin
                errNext[selQ] = 1'b1;
                stateNext     = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lastQ     <= 1'b1;
            selQ      <= REQ_CPU;
            weQ       <= 1'b0;
            gnt       <= 2'b00;
            done      <= 2'b00;
            err       <= 2'b00;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_idx   <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            state     <= stateNext;
            gnt       <= gntNext;
            done      <= doneNext;
            err       <= errNext;
            mem_write <= writeNext;
            mem_read  <= readNext;
            if (loadReq) begin
                selQ      <= pickSel;
                lastQ     <= pickSel;
                weQ       <= reqWe;
                mem_idx   <= reqAddr[IDX_W+1:2];
                mem_wdata <= reqWdata;
            end
            if (captureRd) begin
                rdata <= mem_rdata;
            end
        end
    end

    stbExclusive: assert property (@(posedge clk) disable iff (!rst_n) !(mem_write && mem_read));
    gntOneHot:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

endmodule
